// File: rtl/fetch_if.sv
// fetch_if: decoder/ROM-side signal bundle for fetch_unit; FETCH_PERF_CNT_EN adds counter outputs.
interface fetch_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            Stall;
  logic            Halt;
  logic            Jump;
  logic            BranchEn;
  logic            BranchAccept;
  logic [3:0]      BranchIdx;
  logic            LutWe;
  logic [3:0]      LutAddr;
  logic [PC_W-1:0] LutData;
  logic [PC_W-1:0] ProgCtr;
  logic            InstrValid;
  logic            Done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     CycleCnt;
  logic [15:0]     TakenCnt;
`endif
  modport master (
    output Start, Stall, Halt, Jump, BranchEn, BranchAccept, BranchIdx, LutWe, LutAddr, LutData,
    input  ProgCtr, InstrValid, Done
`ifdef FETCH_PERF_CNT_EN
    , input CycleCnt, TakenCnt
`endif
  );
  modport slave (
    input  Start, Stall, Halt, Jump, BranchEn, BranchAccept, BranchIdx, LutWe, LutAddr, LutData,
    output ProgCtr, InstrValid, Done
`ifdef FETCH_PERF_CNT_EN
    , output CycleCnt, TakenCnt
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing (IDLE/RUN/HALT) with a 16-entry branch-target LUT.
// Define FETCH_PERF_CNT_EN to add saturating CycleCnt/TakenCnt outputs.
module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int START_PC  = 0,
  parameter int LUT_DEPTH = 16
) (
  input logic   Clk,
  input logic   Reset_n,
  fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic            r_done;
  logic [PC_W-1:0] r_lut [LUT_DEPTH];
  logic            w_taken;
  logic [PC_W-1:0] w_target;
  assign w_taken  = bus.Jump | (bus.BranchEn & bus.BranchAccept);
  assign w_target = r_lut[bus.BranchIdx];
  // Running off the top address halts instead of wrapping; a taken branch there still redirects.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
    end else if (r_state == RUN) begin
      if (bus.Halt || (!bus.Stall && !w_taken && r_pc == '1)) begin
        r_state <= HALT;
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end else if (!bus.Stall)
        r_pc <= w_taken ? w_target : r_pc + 1'b1;
    end else begin
      if (bus.LutWe) r_lut[bus.LutAddr] <= bus.LutData;
      if (bus.Start) begin
        r_state <= RUN;
        r_pc    <= PC_W'(START_PC);
        r_valid <= 1'b1;
        r_done  <= 1'b0;
      end
    end
  assign bus.ProgCtr    = r_pc;
  assign bus.InstrValid = r_valid;
  assign bus.Done       = r_done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_cyc;
  logic [15:0] r_tk;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_cyc <= '0;
      r_tk  <= '0;
    end else if (r_state == RUN) begin
      if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
      if (!bus.Halt && !bus.Stall && w_taken && r_tk != '1) r_tk <= r_tk + 1'b1;
    end else if (bus.Start) begin
      r_cyc <= '0;
      r_tk  <= '0;
    end
  assign bus.CycleCnt = r_cyc;
  assign bus.TakenCnt = r_tk;
`endif
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch / program-counter stage directly upstream of the control decoder.
- Holds the PC that addresses instruction ROM and sequences run/stall/halt.
- Consumes the decoder's Jump, BranchEn and BranchAccept outputs.
- Resolves taken branches through an internal 16-entry branch-target lookup table (LUT) indexed by a 4-bit field of the current instruction.

Parameters:
- PC_W, 10, width of program counter and LUT entries
- START_PC, 0, PC value loaded on Start
- LUT_DEPTH, 16, number of branch-target LUT entries (index width = 4)

Ports:
- Clk  input  1  system clock, rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  begin execution from START_PC (honoured in IDLE or HALT only)
- Stall  input  1  hold PC this cycle (multi-cycle memory op)
- Halt  input  1  decoded halt instruction; stop after current instruction
- Jump  input  1  unconditional redirect from decoder
- BranchEn  input  1  current instruction is a branch
- BranchAccept  input  1  branch condition met
- BranchIdx  input  4  LUT index taken from instruction bits
- LutWe  input  1  LUT write enable (accepted in IDLE/HALT only)
- LutAddr  input  4  LUT write address
- LutData  input  PC_W  LUT write data (absolute target)
- ProgCtr  output  PC_W  instruction ROM address
- InstrValid  output  1  ProgCtr addresses a live instruction this cycle
- Done  output  1  program finished; level signal while in HALT

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, ProgCtr=0, InstrValid=0, Done=0.
  - All LUT entries cleared to 0.
- States:
  - IDLE:
    - InstrValid=0, Done=0.
    - Start -> RUN with ProgCtr=START_PC.
    - LutWe writes LutData into LUT[LutAddr] at the clock edge.
  - RUN:
    - InstrValid=1.
    - Priority per cycle: Halt > Stall > taken > increment.
    - taken = Jump | (BranchEn & BranchAccept).
    - Halt=1 -> HALT; ProgCtr unchanged.
    - Stall=1 -> ProgCtr held. Any branch is not lost: the decoder outputs stay stable while the instruction is held, so the branch resolves on the first unstalled cycle.
    - taken -> ProgCtr <= LUT[BranchIdx] next cycle (1-cycle redirect latency, no delay slot).
    - Otherwise ProgCtr <= ProgCtr+1.
    - Start and LutWe are ignored in RUN.
  - HALT:
    - InstrValid=0, Done=1.
    - ProgCtr frozen at the halting instruction.
    - LutWe accepted.
    - Start -> RUN with ProgCtr=START_PC, Done=0 next cycle.
- Boundary conditions:
  - Wrap-around: increment from 2^PC_W-1 does not wrap; enter HALT with ProgCtr held at 2^PC_W-1 (ran off end).
  - A taken branch at that address still redirects normally.
  - LUT read is combinational from BranchIdx.
  - LUT write and read of the same entry in the same cycle is impossible, because writes occur only outside RUN.
  - Start and LutWe together in IDLE: both take effect. The write lands first, so the new entry is visible from the first RUN cycle.
  - Reset mid-RUN or mid-stall: immediate return to IDLE; LUT contents lost.
- Arithmetic: unsigned, PC_W bits; LUT targets are absolute addresses, no offset add.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs CycleCnt[15:0] and TakenCnt[15:0], both cleared on reset and on Start.
  - CycleCnt increments on every RUN cycle, stalled cycles included.
  - TakenCnt increments on every unstalled taken branch in RUN.
  - Both counters saturate at 16'hFFFF and hold their value in HALT.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset_n low during RUN at ProgCtr=37 -> ProgCtr=0, InstrValid=0, Done=0 asynchronously; LUT[3] reads 0 afterwards.
- Write LUT[5]=200 in IDLE, Start, run 3 plain instructions, then BranchEn=1, BranchAccept=1, BranchIdx=5 -> ProgCtr sequence 0,1,2,3,200,201.
- BranchEn=1, BranchAccept=0 at PC=10 -> PC=11; Jump=1, BranchIdx=2 (LUT[2]=50) at PC=11 -> PC=50.
- Stall=1 for 3 cycles with Jump asserted at PC=20, LUT[0]=80 -> PC holds 20 for 3 cycles, then 80.
- Halt=1 and Jump=1 together at PC=42 -> HALT, ProgCtr=42, Done=1, InstrValid=0. A LutWe in HALT is accepted; Start -> PC=START_PC, Done=0.
- PC reaches 1023 (PC_W=10) with no branch -> HALT, ProgCtr=1023, Done=1. With FETCH_PERF_CNT_EN, CycleCnt=1024 and TakenCnt=0 for a straight-line run from 0.
